// File: rtl/rst_seq_sync.sv
// rst_seq_sync
// Multi-channel reset synchroniser and release sequencer for one clock domain.
// An asynchronous active-high RST is asserted immediately. Its release is
// synchronised through a NUM_STAGES flop chain. Reset is then held for
// STRETCH_CYC cycles. After that, the NUM_CH active-low SYNC_RST outputs are
// released one at a time, GAP_CYC cycles apart, starting with bit 0.
//
// Optional feature: define RST_SEQ_SW_REQ_EN to build the software reset
// request path. When it is built, SW_RST_REQ in GAP or DONE restarts the
// stretch and release sequence without touching the synchroniser. When it is
// not built, SW_RST_REQ is ignored.

module rst_seq_sync #(
  parameter int NUM_STAGES  = 2,
  parameter int NUM_CH      = 4,
  parameter int STRETCH_CYC = 8,
  parameter int GAP_CYC     = 4,
  parameter int CNT_W       = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              SW_RST_REQ,
  output logic [NUM_CH-1:0] SYNC_RST,
  output logic              RST_DONE,
  output logic              BUSY
);

  // The index must be able to count one past the last channel.
  localparam int IDX_W = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYC - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    SYNC    = 2'd0,
    STRETCH = 2'd1,
    GAP     = 2'd2,
    DONE    = 2'd3
  } state_t;

  logic [NUM_STAGES-1:0] sync_chain;
  logic                  sync_q;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [NUM_CH-1:0] sync_rst_q, sync_rst_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  // Release synchroniser. It is cleared asynchronously by RST and then
  // shifts in ones, so the last stage rises NUM_STAGES edges after release.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[NUM_STAGES-2:0], 1'b1};
    end
  end

  assign sync_q = sync_chain[NUM_STAGES-1];

  // Register the sequencer state. Every output comes straight from a flop,
  // so the downstream resets cannot glitch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= SYNC;
      cnt_q      <= '0;
      idx_q      <= '0;
      sync_rst_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      sync_rst_q <= sync_rst_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state logic. Each counter only advances until its terminal value,
  // and each terminal value moves the FSM on, so nothing can wrap.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    sync_rst_d = sync_rst_q;
    done_d     = done_q;
    busy_d     = busy_q;

    case (state_q)
      SYNC: begin
        if (sync_q) begin
          state_d = STRETCH;
          cnt_d   = '0;
        end
      end

      STRETCH: begin
        if (cnt_q == STRETCH_LAST) begin
          sync_rst_d[0] = 1'b1;
          cnt_d         = '0;
          idx_d         = IDX_W'(1);
          if (NUM_CH == 1) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = GAP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      GAP: begin
        if (cnt_q == GAP_LAST) begin
          for (int i = 1; i < NUM_CH; i++) begin
            if (idx_q == IDX_W'(i)) begin
              sync_rst_d[i] = 1'b1;
            end
          end
          idx_d = idx_q + IDX_W'(1);
          cnt_d = '0;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: begin
        state_d = DONE;
      end

      default: begin
        state_d = SYNC;
      end
    endcase

`ifdef RST_SEQ_SW_REQ_EN
    // A software request re-enters STRETCH and re-asserts every channel.
    // It has no effect until the first hardware sequence reaches GAP.
    if (SW_RST_REQ && ((state_q == GAP) || (state_q == DONE))) begin
      sync_rst_d = '0;
      done_d     = 1'b0;
      busy_d     = 1'b1;
      state_d    = STRETCH;
      cnt_d      = '0;
      idx_d      = '0;
    end
`endif
  end

`ifndef RST_SEQ_SW_REQ_EN
  // Without the request path, the input is only tied to a sink.
  logic unused_sw_rst_req;
  assign unused_sw_rst_req = SW_RST_REQ;
`endif

  assign SYNC_RST = sync_rst_q;
  assign RST_DONE = done_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_rst_seq_sync.sv
// tb_rst_seq_sync
// Directed bench for rst_seq_sync. It uses the default instance plus a
// NUM_STAGES=3 / NUM_CH=1 / STRETCH_CYC=1 instance. Edge numbers count CLK
// rising edges after RST falls. The software-request checks follow
// RST_SEQ_SW_REQ_EN.

module tb_rst_seq_sync;

  logic       CLK;
  logic       RST;
  logic       SW_RST_REQ;
  logic [3:0] sync_rst;
  logic       rst_done;
  logic       busy;
  logic [0:0] sync_rst_b;
  logic       rst_done_b;
  logic       busy_b;

  int total;
  int bad;
  int cur_edge;

  rst_seq_sync dut (
    .CLK        (CLK),
    .RST        (RST),
    .SW_RST_REQ (SW_RST_REQ),
    .SYNC_RST   (sync_rst),
    .RST_DONE   (rst_done),
    .BUSY       (busy)
  );

  rst_seq_sync #(
    .NUM_STAGES  (3),
    .NUM_CH      (1),
    .STRETCH_CYC (1),
    .GAP_CYC     (4),
    .CNT_W       (8)
  ) dut_b (
    .CLK        (CLK),
    .RST        (RST),
    .SW_RST_REQ (SW_RST_REQ),
    .SYNC_RST   (sync_rst_b),
    .RST_DONE   (rst_done_b),
    .BUSY       (busy_b)
  );

  // Free-running domain clock, 10 time units per period.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic rst_val, input logic sw_val);
    RST        = rst_val;
    SW_RST_REQ = sw_val;
  endtask

  task automatic goToEdge(input int e);
    repeat (e - cur_edge) @(posedge CLK);
    #1;
    cur_edge = e;
  endtask

  task automatic checkMain(input string tag, input logic [3:0] exp_rst,
                           input logic exp_done, input logic exp_busy);
    checkOutput({tag, "_rst"},  32'(sync_rst), 32'(exp_rst));
    checkOutput({tag, "_done"}, 32'(rst_done), 32'(exp_done));
    checkOutput({tag, "_busy"}, 32'(busy),     32'(exp_busy));
  endtask

  // Raise RST mid-cycle, check the asynchronous clear, then drop RST before
  // the next edge. The next rising edge becomes edge 1.
  task automatic pulseRst(input string tag);
    #2;
    applyStimulus(1'b1, 1'b0);
    #1;
    checkMain(tag, 4'b0000, 1'b0, 1'b1);
    #1;
    applyStimulus(1'b0, 1'b0);
    cur_edge = 0;
  endtask

  // Drive a single-cycle request so that it is sampled at edge e.
  task automatic swPulseAt(input int e);
    goToEdge(e - 1);
    SW_RST_REQ = 1'b1;
    goToEdge(e);
    SW_RST_REQ = 1'b0;
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    cur_edge = 0;
    applyStimulus(1'b1, 1'b0);

    // Power-on: hold RST for three cycles, then release it at a falling edge.
    repeat (3) @(posedge CLK);
    #1;
    checkMain("por_hold", 4'b0000, 1'b0, 1'b1);
    checkOutput("por_hold_b", 32'(sync_rst_b), 32'd0);
    @(negedge CLK);
    applyStimulus(1'b0, 1'b0);
    cur_edge = 0;

    goToEdge(4);
    checkOutput("b_e4_rst",  32'(sync_rst_b), 32'd0);
    checkOutput("b_e4_done", 32'(rst_done_b), 32'd0);
    goToEdge(5);
    checkOutput("b_e5_rst",  32'(sync_rst_b), 32'd1);
    checkOutput("b_e5_done", 32'(rst_done_b), 32'd1);
    checkOutput("b_e5_busy", 32'(busy_b),     32'd0);
    goToEdge(10); checkMain("p1_e10", 4'b0000, 1'b0, 1'b1);
    goToEdge(11); checkMain("p1_e11", 4'b0001, 1'b0, 1'b1);
    goToEdge(14); checkMain("p1_e14", 4'b0001, 1'b0, 1'b1);
    goToEdge(15); checkMain("p1_e15", 4'b0011, 1'b0, 1'b1);
    goToEdge(18); checkMain("p1_e18", 4'b0011, 1'b0, 1'b1);
    goToEdge(19); checkMain("p1_e19", 4'b0111, 1'b0, 1'b1);
    goToEdge(22); checkMain("p1_e22", 4'b0111, 1'b0, 1'b1);
    goToEdge(23); checkMain("p1_e23", 4'b1111, 1'b1, 1'b0);
    goToEdge(30); checkMain("p1_e30", 4'b1111, 1'b1, 1'b0);

    // Asynchronous assertion in DONE, followed by an identical resequence.
    pulseRst("async_done");
    goToEdge(10); checkMain("p2_e10", 4'b0000, 1'b0, 1'b1);
    goToEdge(11); checkMain("p2_e11", 4'b0001, 1'b0, 1'b1);
    goToEdge(15); checkMain("p2_e15", 4'b0011, 1'b0, 1'b1);
    goToEdge(23); checkMain("p2_e23", 4'b1111, 1'b1, 1'b0);

    // Software request in DONE at edge 30.
    swPulseAt(30);
`ifdef RST_SEQ_SW_REQ_EN
    checkMain("sw_e30", 4'b0000, 1'b0, 1'b1);
    goToEdge(37); checkMain("sw_e37", 4'b0000, 1'b0, 1'b1);
    goToEdge(38); checkMain("sw_e38", 4'b0001, 1'b0, 1'b1);
    goToEdge(42); checkMain("sw_e42", 4'b0011, 1'b0, 1'b1);
    goToEdge(46); checkMain("sw_e46", 4'b0111, 1'b0, 1'b1);
    goToEdge(49); checkMain("sw_e49", 4'b0111, 1'b0, 1'b1);
    goToEdge(50); checkMain("sw_e50", 4'b1111, 1'b1, 1'b0);
`else
    checkMain("sw_off_e30", 4'b1111, 1'b1, 1'b0);
    goToEdge(38); checkMain("sw_off_e38", 4'b1111, 1'b1, 1'b0);
    goToEdge(50); checkMain("sw_off_e50", 4'b1111, 1'b1, 1'b0);
`endif

    // Reset mid-sequence after ch0 and ch1 have been released.
    pulseRst("async_p3");
    goToEdge(16); checkMain("p3_e16", 4'b0011, 1'b0, 1'b1);
    pulseRst("async_mid");
    goToEdge(10); checkMain("p4_e10", 4'b0000, 1'b0, 1'b1);
    goToEdge(11); checkMain("p4_e11", 4'b0001, 1'b0, 1'b1);
    goToEdge(15); checkMain("p4_e15", 4'b0011, 1'b0, 1'b1);

    // Software requests in SYNC and STRETCH must not disturb the sequence.
    pulseRst("async_p5");
    swPulseAt(2);
    checkMain("p5_e2", 4'b0000, 1'b0, 1'b1);
    swPulseAt(8);
    checkMain("p5_e8", 4'b0000, 1'b0, 1'b1);
    goToEdge(10); checkMain("p5_e10", 4'b0000, 1'b0, 1'b1);
    goToEdge(11); checkMain("p5_e11", 4'b0001, 1'b0, 1'b1);
    goToEdge(15); checkMain("p5_e15", 4'b0011, 1'b0, 1'b1);
    goToEdge(19); checkMain("p5_e19", 4'b0111, 1'b0, 1'b1);
    goToEdge(23); checkMain("p5_e23", 4'b1111, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
